// File: rtl/regfile_bypass_pkg.sv
// -----------------------------------------------------------------------------
// regfile_bypass_pkg
// Shared constants and types for the write-back bus and the register file.
// The WB stage packs {we, waddr, wdata} with the same slice positions used
// here, so packing and unpacking stay in lock-step.
// -----------------------------------------------------------------------------
package regfile_bypass_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int BUS_W  = 1 + ADDR_W + DATA_W;

  // Field positions inside a 38-bit write/forward bus
  localparam int BUS_WE_BIT   = 37;
  localparam int BUS_WADDR_HI = 36;
  localparam int BUS_WADDR_LO = 32;
  localparam int BUS_WDATA_HI = 31;
  localparam int BUS_WDATA_LO = 0;

  // r0 is hardwired to zero and is never a valid write target
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wbus_t;

  // Split a flat bus into its fields using the shared slice positions
  function automatic wbus_t unpack_bus(input logic [BUS_W-1:0] flat);
    wbus_t b;
    b.we    = flat[BUS_WE_BIT];
    b.waddr = flat[BUS_WADDR_HI:BUS_WADDR_LO];
    b.wdata = flat[BUS_WDATA_HI:BUS_WDATA_LO];
    return b;
  endfunction

  // A bus targets a read index only if it writes, and never for r0
  function automatic logic bus_hits(input wbus_t b, input logic [ADDR_W-1:0] idx);
    return b.we && (b.waddr == idx) && (b.waddr != ZERO_REG);
  endfunction

endpackage

// File: rtl/regfile_bypass_if.sv
// -----------------------------------------------------------------------------
// regfile_bypass_if
// Bundles the WB write bus, EX/MEM forward buses, ID read ports, load-use
// stall request and HI/LO access.
//   master : pipeline side (drives buses, read indices, HI/LO writes)
//   slave  : register file side (returns read data, HI/LO, stall request)
// -----------------------------------------------------------------------------
interface regfile_bypass_if;
  import regfile_bypass_pkg::*;

  logic [BUS_W-1:0]  wb_to_rf_bus;
  logic [BUS_W-1:0]  ex_fwd_bus;
  logic              ex_is_load;
  logic [BUS_W-1:0]  mem_fwd_bus;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic              r1_used;
  logic              r2_used;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              stallreq_load;
  logic              wb_hi_we;
  logic              wb_lo_we;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic [DATA_W-1:0] hi_rdata;
  logic [DATA_W-1:0] lo_rdata;

  modport master (
    output wb_to_rf_bus, ex_fwd_bus, ex_is_load, mem_fwd_bus,
    output raddr1, raddr2, r1_used, r2_used,
    output wb_hi_we, wb_lo_we, wb_hi, wb_lo,
    input  rdata1, rdata2, stallreq_load, hi_rdata, lo_rdata
  );

  modport slave (
    input  wb_to_rf_bus, ex_fwd_bus, ex_is_load, mem_fwd_bus,
    input  raddr1, raddr2, r1_used, r2_used,
    input  wb_hi_we, wb_lo_we, wb_hi, wb_lo,
    output rdata1, rdata2, stallreq_load, hi_rdata, lo_rdata
  );

endinterface

// File: rtl/regfile_bypass_bypass_mux.sv
// -----------------------------------------------------------------------------
// bypass_mux
// Priority select for one read port: r0 -> 0, else EX > MEM > WB > array.
// Ports:
//   i_raddr      read index
//   i_ex_bus     EX forward bus (youngest producer)
//   i_mem_bus    MEM forward bus
//   i_wb_bus     WB write bus (oldest in-flight producer)
//   i_array_word stored register word for i_raddr
//   o_rdata      bypassed read data
// -----------------------------------------------------------------------------
module bypass_mux
  import regfile_bypass_pkg::*;
(
  input  logic [ADDR_W-1:0] i_raddr,
  input  wbus_t             i_ex_bus,
  input  wbus_t             i_mem_bus,
  input  wbus_t             i_wb_bus,
  input  logic [DATA_W-1:0] i_array_word,
  output logic [DATA_W-1:0] o_rdata
);

  // Youngest matching producer wins
  always_comb begin
    o_rdata = i_array_word;
    if (i_raddr == ZERO_REG) begin
      o_rdata = '0;
    end else if (bus_hits(i_ex_bus, i_raddr)) begin
      o_rdata = i_ex_bus.wdata;
    end else if (bus_hits(i_mem_bus, i_raddr)) begin
      o_rdata = i_mem_bus.wdata;
    end else if (bus_hits(i_wb_bus, i_raddr)) begin
      o_rdata = i_wb_bus.wdata;
    end else begin
      o_rdata = i_array_word;
    end
  end

endmodule

// File: rtl/regfile_bypass.sv
// -----------------------------------------------------------------------------
// regfile_bypass
// Architectural register file (r1..r31) plus HI/LO at the end of the WB bus.
// Two combinational read ports with EX/MEM/WB forwarding and a load-use
// stall request for the stall controller.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset; clears r1..r31, HI and LO and
//        overrides any write presented in the same cycle
//   bus  regfile_bypass_if.slave (buses, read ports, HI/LO, stall request)
// -----------------------------------------------------------------------------
module regfile_bypass
  import regfile_bypass_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  regfile_bypass_if.slave bus
);

  wbus_t             w_wb;
  wbus_t             w_ex;
  wbus_t             w_mem;

  // r0 is not stored; the array starts at index 1
  logic [DATA_W-1:0] r_regs [1:31];
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic [DATA_W-1:0] w_arr1;
  logic [DATA_W-1:0] w_arr2;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic              w_ex_hit1;
  logic              w_ex_hit2;

  assign w_wb  = unpack_bus(bus.wb_to_rf_bus);
  assign w_ex  = unpack_bus(bus.ex_fwd_bus);
  assign w_mem = unpack_bus(bus.mem_fwd_bus);

  // Committed writes into the array and HI/LO; reset wins over any write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
      end
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_wb.we && (w_wb.waddr != ZERO_REG)) begin
        r_regs[w_wb.waddr] <= w_wb.wdata;
      end
      if (bus.wb_hi_we) begin
        r_hi <= bus.wb_hi;
      end
      if (bus.wb_lo_we) begin
        r_lo <= bus.wb_lo;
      end
    end
  end

  // Array lookup; index 0 has no storage so it is masked here
  always_comb begin
    w_arr1 = '0;
    w_arr2 = '0;
    if (bus.raddr1 != ZERO_REG) begin
      w_arr1 = r_regs[bus.raddr1];
    end else begin
      w_arr1 = '0;
    end
    if (bus.raddr2 != ZERO_REG) begin
      w_arr2 = r_regs[bus.raddr2];
    end else begin
      w_arr2 = '0;
    end
  end

  bypass_mux u_mux1 (
    .i_raddr      (bus.raddr1),
    .i_ex_bus     (w_ex),
    .i_mem_bus    (w_mem),
    .i_wb_bus     (w_wb),
    .i_array_word (w_arr1),
    .o_rdata      (w_rdata1)
  );

  bypass_mux u_mux2 (
    .i_raddr      (bus.raddr2),
    .i_ex_bus     (w_ex),
    .i_mem_bus    (w_mem),
    .i_wb_bus     (w_wb),
    .i_array_word (w_arr2),
    .o_rdata      (w_rdata2)
  );

  assign bus.rdata1 = w_rdata1;
  assign bus.rdata2 = w_rdata2;

  // A load in EX has no data yet; a used operand that needs it must wait a cycle
  assign w_ex_hit1 = bus.r1_used && bus_hits(w_ex, bus.raddr1);
  assign w_ex_hit2 = bus.r2_used && bus_hits(w_ex, bus.raddr2);
  assign bus.stallreq_load = bus.ex_is_load && (w_ex_hit1 || w_ex_hit2);

  // HI/LO are write-through: a WB write is visible in the same cycle
  assign bus.hi_rdata = bus.wb_hi_we ? bus.wb_hi : r_hi;
  assign bus.lo_rdata = bus.wb_lo_we ? bus.wb_lo : r_lo;

endmodule

// File: tb/tb_regfile_bypass.sv
module tb_regfile_bypass;

  logic clk;
  logic t_rst;

  logic        t_wb_we,  t_ex_we,  t_mem_we;
  logic [4:0]  t_wb_addr, t_ex_addr, t_mem_addr;
  logic [31:0] t_wb_data, t_ex_data, t_mem_data;
  logic        t_ld;
  logic [4:0]  t_ra1, t_ra2;
  logic        t_r1u, t_r2u;
  logic        t_hiwe, t_lowe;
  logic [31:0] t_hi, t_lo;

  int total;
  int bad;

  regfile_bypass_if ifc ();

  assign ifc.wb_to_rf_bus = {t_wb_we, t_wb_addr, t_wb_data};
  assign ifc.ex_fwd_bus   = {t_ex_we, t_ex_addr, t_ex_data};
  assign ifc.mem_fwd_bus  = {t_mem_we, t_mem_addr, t_mem_data};
  assign ifc.ex_is_load   = t_ld;
  assign ifc.raddr1       = t_ra1;
  assign ifc.raddr2       = t_ra2;
  assign ifc.r1_used      = t_r1u;
  assign ifc.r2_used      = t_r2u;
  assign ifc.wb_hi_we     = t_hiwe;
  assign ifc.wb_lo_we     = t_lowe;
  assign ifc.wb_hi        = t_hi;
  assign ifc.wb_lo        = t_lo;

  regfile_bypass dut (
    .clk (clk),
    .rst (t_rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_hi, m_lo;

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (t_ex_we  && t_ex_addr  == a) return t_ex_data;
    if (t_mem_we && t_mem_addr == a) return t_mem_data;
    if (t_wb_we  && t_wb_addr  == a) return t_wb_data;
    return m_regs[a];
  endfunction

  function automatic logic ref_stall();
    return t_ld && t_ex_we && (t_ex_addr != 5'd0) &&
           ((t_r1u && t_ex_addr == t_ra1) || (t_r2u && t_ex_addr == t_ra2));
  endfunction

  // Clock edge: the model takes the same inputs the DUT sees
  task automatic tick();
    @(posedge clk);
    if (t_rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_hi = 32'd0;
      m_lo = 32'd0;
    end else begin
      if (t_wb_we && t_wb_addr != 5'd0) m_regs[t_wb_addr] = t_wb_data;
      if (t_hiwe) m_hi = t_hi;
      if (t_lowe) m_lo = t_lo;
    end
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst;
    logic [37:0] wb, ex, mem;
    logic        ld;
    logic [4:0]  ra1, ra2;
    logic        r1u, r2u;
    logic        hiwe, lowe;
    logic [31:0] hi, lo;
    logic        chk, chkd;
    logic [31:0] e_r1, e_r2;
    logic        e_st;
    logic [31:0] e_hi, e_lo;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic logic [37:0] bw(input logic we, input logic [4:0] a, input logic [31:0] d);
    return {we, a, d};
  endfunction

  initial begin
    logic [37:0] n;
    logic [31:0] z;
    logic [31:0] e1, e2;
    logic        es;
    total = 0;
    bad   = 0;
    n = 38'h0;
    z = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_hi = 32'd0;
    m_lo = 32'd0;

    //            rst   wb                          ex                     mem                   ld    ra1   ra2    r1u   r2u   hiwe  lowe  hi       lo       chk   chkd  e_r1           e_r2           e_st  e_hi     e_lo
    vecs[0]  = '{1'b1, n,                          n,                     n,                    1'b0, 5'd0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b0, 1'b0, z,             z,             1'b0, z,       z};
    vecs[1]  = '{1'b0, n,                          n,                     n,                    1'b0, 5'd5, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, z,             z,             1'b0, z,       z};
    vecs[2]  = '{1'b0, bw(1'b1,5'd7,32'hDEADBEEF), n,                     n,                    1'b0, 5'd7, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, 32'hDEADBEEF,  z,             1'b0, z,       z};
    vecs[3]  = '{1'b0, n,                          n,                     n,                    1'b0, 5'd7, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, 32'hDEADBEEF,  z,             1'b0, z,       z};
    vecs[4]  = '{1'b0, bw(1'b1,5'd0,32'h1234),     n,                     n,                    1'b0, 5'd0, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, z,             32'hDEADBEEF,  1'b0, z,       z};
    vecs[5]  = '{1'b0, n,                          n,                     n,                    1'b0, 5'd0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, z,             z,             1'b0, z,       z};
    vecs[6]  = '{1'b0, bw(1'b1,5'd3,32'hC),        bw(1'b1,5'd3,32'hA),   bw(1'b1,5'd3,32'hB),  1'b0, 5'd7, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, 32'hDEADBEEF,  32'hA,         1'b0, z,       z};
    vecs[7]  = '{1'b0, bw(1'b1,5'd3,32'hC),        n,                     bw(1'b1,5'd3,32'hB),  1'b0, 5'd7, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, 32'hDEADBEEF,  32'hB,         1'b0, z,       z};
    vecs[8]  = '{1'b0, bw(1'b1,5'd3,32'hC),        n,                     n,                    1'b0, 5'd7, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, 32'hDEADBEEF,  32'hC,         1'b0, z,       z};
    vecs[9]  = '{1'b0, n,                          n,                     n,                    1'b0, 5'd7, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, 32'hDEADBEEF,  32'hC,         1'b0, z,       z};
    vecs[10] = '{1'b0, n,                          bw(1'b1,5'd9,32'hFFFF),n,                    1'b1, 5'd9, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b0, z,             z,             1'b1, z,       z};
    vecs[11] = '{1'b0, n,                          bw(1'b1,5'd9,32'hFFFF),n,                    1'b1, 5'd9, 5'd3,  1'b0, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, 32'hFFFF,      32'hC,         1'b0, z,       z};
    vecs[12] = '{1'b0, n,                          n,                     bw(1'b1,5'd9,32'h55), 1'b0, 5'd9, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, 32'h55,        32'hC,         1'b0, z,       z};
    vecs[13] = '{1'b0, n,                          bw(1'b1,5'd3,32'hBAD), n,                    1'b1, 5'd5, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b0, z,             z,             1'b1, z,       z};
    vecs[14] = '{1'b0, n,                          bw(1'b1,5'd0,32'h5),   n,                    1'b1, 5'd0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, z,             z,             1'b0, z,       z};
    vecs[15] = '{1'b0, n,                          bw(1'b0,5'd9,32'h7),   n,                    1'b1, 5'd9, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, z,             32'hC,         1'b0, z,       z};
    vecs[16] = '{1'b1, bw(1'b1,5'd4,32'h77),       n,                     n,                    1'b0, 5'd4, 5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 32'h11,  z,       1'b0, 1'b0, z,             z,             1'b0, z,       z};
    vecs[17] = '{1'b0, n,                          n,                     n,                    1'b0, 5'd4, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, z,             z,             1'b0, z,       z};
    vecs[18] = '{1'b0, n,                          n,                     n,                    1'b0, 5'd3, 5'd4,  1'b1, 1'b1, 1'b1, 1'b1, 32'h2,   32'h3,   1'b1, 1'b1, z,             z,             1'b0, 32'h2,   32'h3};
    vecs[19] = '{1'b0, n,                          n,                     n,                    1'b0, 5'd3, 5'd4,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, z,             z,             1'b0, 32'h2,   32'h3};
    vecs[20] = '{1'b0, bw(1'b1,5'd31,32'hCAFEF00D),n,                     n,                    1'b0, 5'd5, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, z,             32'hCAFEF00D,  1'b0, 32'h2,   32'h3};
    vecs[21] = '{1'b0, n,                          n,                     n,                    1'b0, 5'd31,5'd31, 1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, 32'hCAFEF00D,  32'hCAFEF00D,  1'b0, 32'h2,   32'h3};
    vecs[22] = '{1'b0, bw(1'b1,5'd12,32'h111),     bw(1'b1,5'd12,32'h222),n,                    1'b0, 5'd12,5'd31, 1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, 32'h222,       32'hCAFEF00D,  1'b0, 32'h2,   32'h3};
    vecs[23] = '{1'b0, n,                          n,                     n,                    1'b0, 5'd12,5'd31, 1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, 32'h111,       32'hCAFEF00D,  1'b0, 32'h2,   32'h3};
    vecs[24] = '{1'b0, n,                          n,                     n,                    1'b0, 5'd0, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 32'h44,  32'h99,  1'b1, 1'b1, z,             z,             1'b0, 32'h44,  32'h3};
    vecs[25] = '{1'b0, n,                          n,                     n,                    1'b0, 5'd0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, z,       z,       1'b1, 1'b1, z,             z,             1'b0, 32'h44,  32'h3};

    for (int i = 0; i < NV; i++) begin
      t_rst = vecs[i].rst;
      {t_wb_we,  t_wb_addr,  t_wb_data}  = vecs[i].wb;
      {t_ex_we,  t_ex_addr,  t_ex_data}  = vecs[i].ex;
      {t_mem_we, t_mem_addr, t_mem_data} = vecs[i].mem;
      t_ld   = vecs[i].ld;
      t_ra1  = vecs[i].ra1;
      t_ra2  = vecs[i].ra2;
      t_r1u  = vecs[i].r1u;
      t_r2u  = vecs[i].r2u;
      t_hiwe = vecs[i].hiwe;
      t_lowe = vecs[i].lowe;
      t_hi   = vecs[i].hi;
      t_lo   = vecs[i].lo;
      @(negedge clk);
      if (vecs[i].chk) begin
        chk($sformatf("vec%0d stall", i), {31'd0, ifc.stallreq_load}, {31'd0, vecs[i].e_st});
        if (vecs[i].chkd) begin
          chk($sformatf("vec%0d rdata1", i), ifc.rdata1, vecs[i].e_r1);
          chk($sformatf("vec%0d rdata2", i), ifc.rdata2, vecs[i].e_r2);
        end
        chk($sformatf("vec%0d hi", i), ifc.hi_rdata, vecs[i].e_hi);
        chk($sformatf("vec%0d lo", i), ifc.lo_rdata, vecs[i].e_lo);
      end
      tick();
    end

    // ---------------- randomized phase against the model ----------------
    for (int c = 0; c < 400; c++) begin
      t_rst      = ($urandom_range(0, 49) == 0);
      t_wb_we    = $urandom_range(0, 1) == 1;
      t_ex_we    = $urandom_range(0, 1) == 1;
      t_mem_we   = $urandom_range(0, 1) == 1;
      t_wb_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      t_ex_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      t_mem_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      t_ra1      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      t_ra2      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      t_wb_data  = $urandom;
      t_ex_data  = $urandom;
      t_mem_data = $urandom;
      t_ld       = $urandom_range(0, 2) == 0;
      t_r1u      = $urandom_range(0, 3) != 0;
      t_r2u      = $urandom_range(0, 3) != 0;
      t_hiwe     = $urandom_range(0, 2) == 0;
      t_lowe     = $urandom_range(0, 2) == 0;
      t_hi       = $urandom;
      t_lo       = $urandom;
      @(negedge clk);
      es = ref_stall();
      e1 = ref_rd(t_ra1);
      e2 = ref_rd(t_ra2);
      chk($sformatf("rnd%0d stall", c), {31'd0, ifc.stallreq_load}, {31'd0, es});
      if (!es) begin
        chk($sformatf("rnd%0d rdata1", c), ifc.rdata1, e1);
        chk($sformatf("rnd%0d rdata2", c), ifc.rdata2, e2);
      end
      chk($sformatf("rnd%0d hi", c), ifc.hi_rdata, t_hiwe ? t_hi : m_hi);
      chk($sformatf("rnd%0d lo", c), ifc.lo_rdata, t_lowe ? t_lo : m_lo);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- Architectural register file at the receiving end of the write-back bus. Also holds the HI/LO pair.
- Consumes the WB-stage write bus: {we, waddr[4:0], wdata[31:0]}, 38 bits.
- Serves the ID stage with two combinational read ports.
- Forwards in-flight results from the EX, MEM and WB buses onto those ports.
- Raises a load-use stall request to the stall controller.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- BUS_W, 38, width of each write/forward bus, = 1 + ADDR_W + DATA_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wb_to_rf_bus  in  BUS_W  {we, waddr, wdata} from WB; committed write.
- ex_fwd_bus  in  BUS_W  {we, waddr, wdata} of instruction currently in EX.
- ex_is_load  in  1  EX instruction is a load; its wdata is not yet valid.
- mem_fwd_bus  in  BUS_W  {we, waddr, wdata} of instruction currently in MEM.
- raddr1  in  ADDR_W  read index, port 1 (rs).
- raddr2  in  ADDR_W  read index, port 2 (rt).
- r1_used  in  1  ID instruction actually reads port 1.
- r2_used  in  1  ID instruction actually reads port 2.
- rdata1  out  DATA_W  read data, port 1, after bypass.
- rdata2  out  DATA_W  read data, port 2, after bypass.
- stallreq_load  out  1  load-use hazard; request stall of IF/ID.
- wb_hi_we  in  1  write HI at WB.
- wb_lo_we  in  1  write LO at WB.
- wb_hi  in  DATA_W  HI write data.
- wb_lo  in  DATA_W  LO write data.
- hi_rdata  out  DATA_W  HI value, write-through bypassed.
- lo_rdata  out  DATA_W  LO value, write-through bypassed.

Behaviour:

Storage:
- reg[1..31] and HI/LO are registers. reg[0] is not stored and always reads 0.

Reset:
- On posedge clk with rst=1, all 31 registers, HI and LO are cleared to 0.
- rst overrides any simultaneous WB write. A write presented in the reset cycle is lost.
- Immediately after reset, rdata1/2, hi_rdata and lo_rdata read 0, given no forwarding bus is active.
- stallreq_load is purely combinational. It is 0 whenever the EX bus is idle.

Write:
- On posedge clk with rst=0 and wb we=1 and waddr!=0: reg[waddr] <= wdata.
- A write with waddr=0 is discarded.
- Latency is 1 cycle into the array. The bypass path makes the data visible in the same cycle.

Read (combinational), per port N:
- raddrN=0 -> 0.
- Else if ex we && ex waddr==raddrN -> ex wdata.
- Else if mem we && mem waddr==raddrN -> mem wdata.
- Else if wb we && wb waddr==raddrN -> wb wdata.
- Else -> reg[raddrN].
- The priority order is EX > MEM > WB, so the youngest producer wins.
- Forward buses with waddr=0 never match.

Load-use detection:
- stallreq_load = ex_is_load && ex we && ex waddr!=0 && ((r1_used && ex waddr==raddr1) || (r2_used && ex waddr==raddr2)).
- While stallreq_load=1, rdata is don't-care. The stage controller holds ID and bubbles EX.
- On the next cycle the load sits in MEM. mem wdata then carries the loaded value and the MEM forward path resolves the hazard.

HI/LO:
- Written independently at posedge when the corresponding we=1 and rst=0.
- Each read output returns its WB write data when the matching we=1, else the stored value.
- Simultaneous HI and LO writes are both taken.

Simultaneous events:
- WB writing reg X while EX also targets X: the array takes the WB data; the read port returns the EX data.
- Both ports reading the same index: both return identical data.

Decomposition:
- Shared defines file holds:
  - BUS_W and its field slice positions (we at bit 37, waddr 36:32, wdata 31:0).
  - The zero-register index constant.
- These are the same constants the WB stage uses, so packing and unpacking match.
- One sub-module is natural: bypass_mux, a single read port's priority select.
  - Inputs: raddr, the three buses, the array word.
  - Instantiated twice.
- HI/LO bypass is inline.

Test Plan:
1. Reset, then read raddr1=5, raddr2=31 with all buses idle -> rdata1=0, rdata2=0, hi_rdata=lo_rdata=0, stallreq_load=0.
2. WB write {1,5'd7,32'hDEADBEEF}, raddr1=7 in the same cycle -> rdata1=DEADBEEF via bypass. Next cycle with WB idle -> still DEADBEEF from the array.
3. WB write to r0 with data 32'h1234 -> raddr1=0 reads 0 both in that cycle and the next.
4. Priority: EX {1,3,32'hA}, MEM {1,3,32'hB}, WB {1,3,32'hC}, raddr2=3 -> rdata2=A. Drop EX -> B. Drop MEM -> C. Next cycle -> reg[3]=C.
5. Load-use:
   - ex_is_load=1, EX bus {1,9,x}, raddr1=9, r1_used=1 -> stallreq_load=1.
   - Same with r1_used=0 -> 0.
   - Next cycle with MEM bus {1,9,32'h55} -> stallreq_load=0, rdata1=55.
6. WB write r4=32'h77 and HI=32'h11 with rst=1 in the same cycle -> after reset, reg[4]=0 and hi_rdata=0. Then wb_hi_we=1, wb_lo_we=1 with hi=2, lo=3 -> same-cycle read 2/3, and held at 2/3 afterwards.
